axil_ls_frontend: RTL
=====================

AXIL_LS_FRONTEND -- requirements
Module: axil_ls_frontend

Interface
REQ-001 The block SHALL have one clock and synchronous active-high reset; params: ADDR_W default 15, byte address width; RD_TIMEOUT default 255, cycles waited for bk_ls_rdone.
REQ-002 axi_aclk  in  1  sole clock, all logic on rising edge.
REQ-003 axi_reset  in  1  synchronous, active-high reset.
REQ-004 axi_awaddr  in  15  write address.
REQ-005 axi_awvalid / axi_awready  in / out  1  AW handshake.
REQ-006 axi_wdata  in  32  write data.
REQ-007 axi_wstrb  in  4  write byte strobes.
REQ-008 axi_wvalid / axi_wready  in / out  1  W handshake.
REQ-009 axi_bresp  out  2  write response.
REQ-010 axi_bvalid / axi_bready  out / in  1  B handshake.
REQ-011 axi_araddr  in  15  read address.
REQ-012 axi_arvalid / axi_arready  in / out  1  AR handshake.
REQ-013 axi_rdata  out  32  read data.
REQ-014 axi_rresp  out  2  read response.
REQ-015 axi_rvalid / axi_rready  out / in  1  R handshake.
REQ-016 bk_ls_wstart  out  1  one-cycle backend write pulse.
REQ-017 bk_ls_waddr / bk_ls_wdata / bk_ls_wstrb  out  15/32/4  write payload, valid with wstart.
REQ-018 bk_ls_rstart  out  1  one-cycle backend read pulse.
REQ-019 bk_ls_raddr  out  15  read address, valid with rstart.
REQ-020 bk_ls_rdata  in  32  read return data, sampled with rdone.
REQ-021 bk_ls_rdone  in  1  one-cycle read completion.

Function
REQ-022 AW and W SHALL be captured independently into holding registers; axi_awready (axi_wready) high exactly when its holding register is empty, in any FSM state.
REQ-023 FSM states SHALL be IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP; one transaction outstanding at a time.
REQ-024 axi_arready SHALL be high only in IDLE and only when no complete AW+W pair is held or the last served transaction was a write (alternating priority, write first after reset).
REQ-025 IDLE with complete AW+W pair and write selected -> WR_ISSUE: bk_ls_wstart=1 for exactly one cycle with held payload, both holding registers freed that cycle.
REQ-026 WR_ISSUE -> WR_RESP: axi_bvalid=1, axi_bresp=2'b00; held until axi_bready, then IDLE.
REQ-027 AR handshake -> RD_ISSUE: bk_ls_rstart=1 for one cycle with captured address; then RD_WAIT with timeout counter cleared.
REQ-028 RD_WAIT: bk_ls_rdone=1 -> latch bk_ls_rdata, RD_RESP with axi_rresp=2'b00; counter reaching RD_TIMEOUT without rdone -> RD_RESP with axi_rdata=32'hFFFF_FFFF, axi_rresp=2'b10.
REQ-029 rdone in the same cycle the counter reaches RD_TIMEOUT SHALL win (OKAY, real data); rdone outside RD_WAIT SHALL be ignored.
REQ-030 RD_RESP: axi_rvalid=1, rdata/rresp stable until axi_rready, then IDLE.
REQ-031 Minimum latency: AW+W accepted cycle N -> wstart N+1, bvalid N+2; AR accepted N -> rstart N+1.

Reset
REQ-032 In any cycle with axi_reset=1: all outputs 0 except awready/wready, which go to 1 the first cycle after reset releases; FSM IDLE, holds empty, priority write-first, counter 0; in-flight transaction dropped with no response.

Structure
REQ-033 Package axil_ls_pkg SHALL hold the FSM state enum and constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10; the block is flat, no sub-module.

Verification
REQ-034 AW(0x0010) and W(0xDEADBEEF, strb 0xF) same cycle -> one wstart pulse carrying them, then bresp=00 after bready.
REQ-035 W two cycles before AW(0x0004) -> no wstart until AW accepted; wready low meanwhile after W capture.
REQ-036 AR(0x0020), rdone after 5 cycles with 0x12345678 -> rdata=0x12345678, rresp=00.
REQ-037 AR, no rdone, RD_TIMEOUT=16 -> after 16 RD_WAIT cycles rdata=0xFFFFFFFF, rresp=10; late rdone ignored.
REQ-038 Write pair and AR pending together for 4 transactions -> order write, read, write, read.
REQ-039 Reset asserted in RD_WAIT -> no rvalid; next AR served normally.

Source files
------------

// File: rtl/axil_ls_pkg.sv
// Shared definitions for the AXI4-Lite to load/store backend frontend.
// Holds the transaction FSM state encoding and the AXI response codes.
package axil_ls_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ISSUE = 3'd1,
        ST_WR_RESP  = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_RD_RESP  = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_ls_frontend.sv
// AXI4-Lite slave frontend that turns single AXI transactions into one-cycle
// load/store pulses for a simple backend.
//
// Ports:
//   axi_aclk, axi_reset          clock, synchronous active-high reset
//   axi_aw*/axi_w*/axi_b*        AXI write address, data and response channels
//   axi_ar*/axi_r*               AXI read address and data channels
//   bk_ls_wstart/waddr/wdata/wstrb   one-cycle backend write command
//   bk_ls_rstart/raddr               one-cycle backend read command
//   bk_ls_rdata/rdone                backend read completion (one-cycle)
//
// AW and W are buffered independently in single-entry holding registers.
// Only one transaction is in flight; reads and writes alternate when both are
// pending, with writes preferred after reset. A read that gets no rdone within
// RD_TIMEOUT wait cycles completes with SLVERR and all-ones data.
module axil_ls_frontend
    import axil_ls_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              axi_aclk,
    input  logic              axi_reset,
    input  logic [ADDR_W-1:0] axi_awaddr,
    input  logic              axi_awvalid,
    output logic              axi_awready,
    input  logic [31:0]       axi_wdata,
    input  logic [3:0]        axi_wstrb,
    input  logic              axi_wvalid,
    output logic              axi_wready,
    output logic [1:0]        axi_bresp,
    output logic              axi_bvalid,
    input  logic              axi_bready,
    input  logic [ADDR_W-1:0] axi_araddr,
    input  logic              axi_arvalid,
    output logic              axi_arready,
    output logic [31:0]       axi_rdata,
    output logic [1:0]        axi_rresp,
    output logic              axi_rvalid,
    input  logic              axi_rready,
    output logic              bk_ls_wstart,
    output logic [ADDR_W-1:0] bk_ls_waddr,
    output logic [31:0]       bk_ls_wdata,
    output logic [3:0]        bk_ls_wstrb,
    output logic              bk_ls_rstart,
    output logic [ADDR_W-1:0] bk_ls_raddr,
    input  logic [31:0]       bk_ls_rdata,
    input  logic              bk_ls_rdone
);

    localparam int CNT_W = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);

    state_t state_reg, state_next;

    logic              aw_full_reg;
    logic [ADDR_W-1:0] aw_addr_reg;
    logic              w_full_reg;
    logic [31:0]       w_data_reg;
    logic [3:0]        w_strb_reg;
    logic [ADDR_W-1:0] ar_addr_reg;
    logic              last_wr_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [31:0]       rdata_reg;
    logic [1:0]        rresp_reg;

    logic run;
    logic aw_hs, w_hs, ar_hs;
    logic pair_avail;
    logic timeout_hit;
    logic wstart_c, rstart_c, bvalid_c, rvalid_c;

    // Outputs are forced low combinationally while reset is asserted, so even
    // the first reset cycle (before the registers clear) shows all zeros.
    assign run = ~axi_reset;

    assign axi_awready = run & ~aw_full_reg;
    assign axi_wready  = run & ~w_full_reg;
    assign aw_hs       = axi_awvalid & axi_awready;
    assign w_hs        = axi_wvalid & axi_wready;

    // A pair counts as available if it is held or completing this cycle; this
    // lets a write go straight to WR_ISSUE on the cycle after its handshake.
    assign pair_avail  = (aw_full_reg | aw_hs) & (w_full_reg | w_hs);

    // Reads are blocked while a write pair is ready unless the last served
    // transaction was a write, which yields strict alternation under load.
    assign axi_arready = run & (state_reg == ST_IDLE) & (~pair_avail | last_wr_reg);
    assign ar_hs       = axi_arvalid & axi_arready;

    // Counter holds the number of completed RD_WAIT cycles; this cycle is the
    // RD_TIMEOUT-th one when it equals RD_TIMEOUT-1.
    assign timeout_hit = (cnt_reg == CNT_W'(RD_TIMEOUT - 1));

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        wstart_c   = 1'b0;
        rstart_c   = 1'b0;
        bvalid_c   = 1'b0;
        rvalid_c   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (ar_hs) begin
                    state_next = ST_RD_ISSUE;
                end else if (pair_avail) begin
                    state_next = ST_WR_ISSUE;
                end
            end
            ST_WR_ISSUE: begin
                wstart_c   = 1'b1;
                state_next = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                bvalid_c = 1'b1;
                if (axi_bready) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RD_ISSUE: begin
                rstart_c   = 1'b1;
                state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (bk_ls_rdone || timeout_hit) begin
                    state_next = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                rvalid_c = 1'b1;
                if (axi_rready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            aw_full_reg <= 1'b0;
            aw_addr_reg <= '0;
            w_full_reg  <= 1'b0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            ar_addr_reg <= '0;
            last_wr_reg <= 1'b0;
            cnt_reg     <= '0;
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
        end else begin
            // Holds are full throughout WR_ISSUE, so no capture can collide
            // with the release.
            if (aw_hs) begin
                aw_full_reg <= 1'b1;
                aw_addr_reg <= axi_awaddr;
            end else if (state_reg == ST_WR_ISSUE) begin
                aw_full_reg <= 1'b0;
            end
            if (w_hs) begin
                w_full_reg <= 1'b1;
                w_data_reg <= axi_wdata;
                w_strb_reg <= axi_wstrb;
            end else if (state_reg == ST_WR_ISSUE) begin
                w_full_reg <= 1'b0;
            end

            if (ar_hs) begin
                ar_addr_reg <= axi_araddr;
                last_wr_reg <= 1'b0;
            end else if (state_reg == ST_IDLE && state_next == ST_WR_ISSUE) begin
                last_wr_reg <= 1'b1;
            end

            if (state_reg == ST_RD_ISSUE) begin
                cnt_reg <= '0;
            end else if (state_reg == ST_RD_WAIT) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end

            // rdone is checked first so it wins over a simultaneous timeout.
            if (state_reg == ST_RD_WAIT) begin
                if (bk_ls_rdone) begin
                    rdata_reg <= bk_ls_rdata;
                    rresp_reg <= RESP_OKAY;
                end else if (timeout_hit) begin
                    rdata_reg <= 32'hFFFF_FFFF;
                    rresp_reg <= RESP_SLVERR;
                end
            end
        end
    end

    assign axi_bvalid   = run & bvalid_c;
    assign axi_bresp    = RESP_OKAY;
    assign axi_rvalid   = run & rvalid_c;
    assign axi_rdata    = run ? rdata_reg : '0;
    assign axi_rresp    = run ? rresp_reg : '0;
    assign bk_ls_wstart = run & wstart_c;
    assign bk_ls_waddr  = run ? aw_addr_reg : '0;
    assign bk_ls_wdata  = run ? w_data_reg : '0;
    assign bk_ls_wstrb  = run ? w_strb_reg : '0;
    assign bk_ls_rstart = run & rstart_c;
    assign bk_ls_raddr  = run ? ar_addr_reg : '0;

endmodule
